// File: rtl/spi_pkg.sv
// Shared SPI constants and state encodings for the transmit and receive paths.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 32;
    localparam int unsigned SPI_LEN_W  = 16;

    // Transmit FSM encoding
    typedef enum logic [1:0] {
        TxIdle     = 2'd0,
        TxWaitData = 2'd1,
        TxShift    = 2'd2
    } tx_state_e;

    // Receive FSM encoding, kept alongside so both paths share one numbering
    typedef enum logic [1:0] {
        RxIdle     = 2'd0,
        RxWaitData = 2'd1,
        RxShift    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_tx_if.sv
// Valid/ready word stream feeding the SPI transmit path.
interface spi_tx_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
) ();

    logic [DATA_W-1:0] tx_data_i;
    logic              tx_data_vld_i;
    logic              tx_data_rdy_o;

    modport master (
        output tx_data_i,
        output tx_data_vld_i,
        input  tx_data_rdy_o
    );

    modport slave (
        input  tx_data_i,
        input  tx_data_vld_i,
        output tx_data_rdy_o
    );

endinterface

// File: rtl/spi_tx_buf.sv
// One-entry holding register between the word stream and the shifter.
module spi_tx_buf
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;

    // Capture on push, release on pop; the caller never does both at once
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (push_i) begin
            r_full <= 1'b1;
            r_data <= data_i;
        end else if (pop_i) begin
            r_full <= 1'b0;
        end
    end

    assign full_o = r_full;
    assign data_o = r_data;

endmodule

// File: rtl/spi_tx.sv
// SPI transmit datapath: buffers words and shifts them out MSB-first on tx_edge_i.
module spi_tx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W,
    parameter int unsigned LEN_W  = SPI_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             tx_edge_i,
    input  logic [LEN_W-1:0] tx_bits_len_i,
    input  logic             tx_bits_len_update_i,
    spi_tx_if.slave          tx_if,
    output logic             sdo,
    output logic             tx_done_o,
    output logic             tx_busy_o,
    output logic             tx_underrun_o
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    tx_state_e         r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_shift;
    logic              r_done;
    logic              r_underrun;

    logic              w_buf_full;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_push;
    logic              w_pop;
    logic [LEN_W-1:0]  w_cnt_inc;
    logic              w_last;
    logic              w_word_end;

    assign w_cnt_inc  = r_cnt + LEN_W'(1);
    assign w_last     = (w_cnt_inc == r_len);
    assign w_word_end = (r_cnt[IDX_W-1:0] == IDX_W'(DATA_W - 1));
    assign w_push     = tx_if.tx_data_vld_i & ~w_buf_full;

    spi_tx_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (tx_if.tx_data_i),
        .full_o  (w_buf_full),
        .data_o  (w_buf_data)
    );

    // Buffer is drained on the initial load and on a seamless word-boundary reload
    always_comb begin
        w_pop = 1'b0;
        if (en_i && w_buf_full) begin
            case (r_state)
                TxWaitData: w_pop = 1'b1;
                TxShift:    w_pop = tx_edge_i & ~w_last & w_word_end;
                default:    w_pop = 1'b0;
            endcase
        end
    end

    // Transfer FSM with bit counter, shifter and registered status pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= TxIdle;
            r_cnt      <= '0;
            r_len      <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                TxIdle: begin
                    if (tx_bits_len_update_i) begin
                        r_len <= tx_bits_len_i;
                    end
                    if (en_i && (r_len != '0)) begin
                        r_state <= TxWaitData;
                        r_cnt   <= '0;
                    end
                end
                TxWaitData: begin
                    if (!en_i) begin
                        r_state <= TxIdle;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else begin
                        // Edge with nothing loaded: flag it, do not count it
                        r_underrun <= tx_edge_i;
                        if (w_buf_full) begin
                            r_shift <= w_buf_data;
                            r_state <= TxShift;
                        end
                    end
                end
                TxShift: begin
                    if (!en_i) begin
                        r_state <= TxIdle;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else if (tx_edge_i) begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= TxIdle;
                            r_cnt   <= '0;
                            r_shift <= '0;
                        end else if (w_word_end) begin
                            r_cnt <= w_cnt_inc;
                            if (w_buf_full) begin
                                r_shift <= w_buf_data;
                            end else begin
                                r_shift <= '0;
                                r_state <= TxWaitData;
                            end
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    r_state <= TxIdle;
                    r_cnt   <= '0;
                    r_shift <= '0;
                end
            endcase
        end
    end

    assign sdo                 = r_shift[DATA_W-1];
    assign tx_done_o           = r_done;
    assign tx_underrun_o       = r_underrun;
    assign tx_busy_o           = (r_state != TxIdle);
    assign tx_if.tx_data_rdy_o = ~w_buf_full;

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: bit-stream reference model plus directed and random traffic.
module tb_spi_tx;
    import spi_pkg::*;

    localparam int unsigned DW = SPI_DATA_W;
    localparam int unsigned LW = SPI_LEN_W;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          tx_edge = 1'b0;
    logic          len_upd = 1'b0;
    logic [LW-1:0] len_in  = '0;
    logic          sdo;
    logic          done;
    logic          busy;
    logic          under;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int under_cnt = 0;
    logic [63:0] cap;

    spi_tx_if #(.DATA_W(DW)) tx_if ();

    spi_tx #(
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .en_i                 (en),
        .tx_edge_i            (tx_edge),
        .tx_bits_len_i        (len_in),
        .tx_bits_len_update_i (len_upd),
        .tx_if                (tx_if),
        .sdo                  (sdo),
        .tx_done_o            (done),
        .tx_busy_o            (busy),
        .tx_underrun_o        (under)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is a stream of len bits; sdo is bit (sent mod DW) of the
    // word currently held, counted from the MSB, or 0 when no word is held.
    bit          m_active, m_have, m_buf_full, m_done, m_under;
    logic [DW-1:0] m_word, m_buf;
    int          m_sent, m_len;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_have = 0; m_buf_full = 0; m_done = 0; m_under = 0;
            m_word = '0; m_buf = '0; m_sent = 0; m_len = 0;
        end else begin
            bit pop, push;
            push = tx_if.tx_data_vld_i && !m_buf_full;
            pop = 0; m_done = 0; m_under = 0;
            if (!m_active) begin
                if (en && m_len != 0) begin
                    m_active = 1; m_have = 0; m_sent = 0;
                end
                if (len_upd) m_len = int'(len_in);
            end else if (!en) begin
                m_active = 0; m_have = 0; m_sent = 0;
            end else if (!m_have) begin
                if (tx_edge) m_under = 1;
                if (m_buf_full) begin
                    m_word = m_buf; m_have = 1; pop = 1;
                end
            end else if (tx_edge) begin
                if (m_sent + 1 == m_len) begin
                    m_done = 1; m_active = 0; m_have = 0; m_sent = 0;
                end else begin
                    m_sent++;
                    if (m_sent % DW == 0) begin
                        if (m_buf_full) begin
                            m_word = m_buf; pop = 1;
                        end else begin
                            m_have = 0;
                        end
                    end
                end
            end
            if (pop) m_buf_full = 0;
            if (push) begin
                m_buf_full = 1; m_buf = tx_if.tx_data_i;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_sdo;
        exp_sdo = m_have ? m_word[DW - 1 - (m_sent % DW)] : 1'b0;
        check("sdo", sdo, exp_sdo);
        check("done", done, m_done);
        check("busy", busy, m_active);
        check("underrun", under, m_under);
        check("rdy", tx_if.tx_data_rdy_o, !m_buf_full);
        if (done) done_cnt++;
        if (under) under_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_len(input int l);
        len_in = LW'(l);
        len_upd = 1'b1;
        tick();
        len_upd = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        int t;
        t = 0;
        while (!tx_if.tx_data_rdy_o && t < 1000) begin
            tick();
            t++;
        end
        check("push_timeout", (t >= 1000), 0);
        tx_if.tx_data_i = w;
        tx_if.tx_data_vld_i = 1'b1;
        tick();
        tx_if.tx_data_vld_i = 1'b0;
    endtask

    // Wait gap cycles, optionally record the presented bit, then strobe one edge
    task automatic pulse_edge(input int gap, input bit rec);
        repeat (gap) tick();
        if (rec) cap = {cap[62:0], sdo};
        tx_edge = 1'b1;
        tick();
        tx_edge = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, u0;
        tx_if.tx_data_i = '0;
        tx_if.tx_data_vld_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_sdo", sdo, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", tx_if.tx_data_rdy_o, 1);
        check("rst_done", done, 0);

        // Single word
        set_len(32);
        push(32'hA5A5_0F0F);
        en = 1'b1;
        repeat (4) tick();
        cap = '0; d0 = done_cnt;
        for (int i = 0; i < 31; i++) pulse_edge(3, 1);
        check("single_no_early_done", done_cnt - d0, 0);
        pulse_edge(3, 1);
        en = 1'b0;
        tick();
        check("single_bits", cap[31:0], 32'hA5A5_0F0F);
        check("single_done", done_cnt - d0, 1);
        check("single_busy", busy, 0);
        check("single_sdo", sdo, 0);

        // Two words, second refilled while the first is shifting
        set_len(64);
        push(32'hFFFF_0000);
        en = 1'b1;
        repeat (4) tick();
        push(32'h1234_5678);
        cap = '0; d0 = done_cnt; u0 = under_cnt;
        for (int i = 0; i < 64; i++) pulse_edge(3, 1);
        en = 1'b0;
        tick();
        check("multi_bits", cap, 64'hFFFF_0000_1234_5678);
        check("multi_underrun", under_cnt - u0, 0);
        check("multi_done", done_cnt - d0, 1);

        // Underrun in the middle of a two-word transfer
        set_len(64);
        push(32'hC3C3_5A5A);
        en = 1'b1;
        repeat (4) tick();
        cap = '0; d0 = done_cnt; u0 = under_cnt;
        for (int i = 0; i < 32; i++) pulse_edge(3, 1);
        for (int i = 0; i < 3; i++) pulse_edge(3, 0);
        tick();
        check("under_count", under_cnt - u0, 3);
        check("under_busy", busy, 1);
        push(32'h0F0F_F0F0);
        repeat (3) tick();
        for (int i = 0; i < 32; i++) pulse_edge(3, 1);
        en = 1'b0;
        tick();
        check("under_bits", cap, 64'hC3C3_5A5A_0F0F_F0F0);
        check("under_done", done_cnt - d0, 1);

        // Partial final word; a queued word stays in the buffer
        set_len(12);
        push(32'hABC0_0000);
        en = 1'b1;
        repeat (4) tick();
        push(32'h1111_1111);
        cap = '0; d0 = done_cnt;
        for (int i = 0; i < 12; i++) pulse_edge(3, 1);
        en = 1'b0;
        tick();
        check("partial_bits", cap[11:0], 12'hABC);
        check("partial_done", done_cnt - d0, 1);
        check("partial_rdy", tx_if.tx_data_rdy_o, 0);

        // Abort mid-word with a word buffered
        set_len(32);
        en = 1'b1;
        repeat (4) tick();
        push(32'h2222_2222);
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) pulse_edge(3, 0);
        en = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_sdo", sdo, 0);
        check("abort_buf_kept", tx_if.tx_data_rdy_o, 0);

        // Length strobe while busy is ignored
        en = 1'b1;
        repeat (4) tick();
        cap = '0; d0 = done_cnt;
        for (int i = 0; i < 5; i++) pulse_edge(3, 1);
        len_in = LW'(5);
        len_upd = 1'b1;
        tick();
        len_upd = 1'b0;
        check("lenupd_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 27; i++) pulse_edge(3, 1);
        en = 1'b0;
        tick();
        check("lenupd_bits", cap[31:0], 32'h2222_2222);
        check("lenupd_done", done_cnt - d0, 1);

        // Asynchronous reset mid-shift with a word buffered
        push(32'h89AB_CDEF);
        en = 1'b1;
        repeat (4) tick();
        push(32'h7654_3210);
        for (int i = 0; i < 8; i++) pulse_edge(3, 0);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_rdy", tx_if.tx_data_rdy_o, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_sdo", sdo, 0);
        check("arst_busy", busy, 0);
        check("arst_rdy", tx_if.tx_data_rdy_o, 1);
        check("arst_done", done, 0);
        check("arst_under", under, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        repeat (3) tick();
        check("zero_len_idle", busy, 0);
        en = 1'b0;
        tick();

        // Random transfers against the model
        for (int t = 0; t < 40; t++) begin
            int l, budget, abort_at;
            bit abort_it, timed_out;
            l = $urandom_range(1, 100);
            abort_it = ($urandom_range(0, 7) == 0);
            abort_at = $urandom_range(1, 60);
            timed_out = 0;
            budget = 0;
            set_len(l);
            en = 1'b1;
            while (1) begin
                tx_edge = ($urandom_range(0, 2) == 0);
                tx_if.tx_data_vld_i = 1'($urandom_range(0, 1));
                tx_if.tx_data_i = $urandom;
                tick();
                budget++;
                if (done) break;
                if (abort_it && budget == abort_at) break;
                if (budget > 3000) begin
                    timed_out = 1;
                    break;
                end
            end
            tx_edge = 1'b0;
            tx_if.tx_data_vld_i = 1'b0;
            en = 1'b0;
            check("rand_timeout", timed_out, 0);
            tick();
            tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
